// File: rtl/axis_polar_clip_framer.sv
// axis_polar_clip_framer: multi-lane AXI4-Stream polar clipper with TLAST regeneration.
// Lanes whose |x|^2 exceeds thresh_sq are attenuated by an arithmetic right shift.
// Three-stage bubble-collapsing pipeline: S1 squares, S2 sum/compare/shift, S3 output.
// Optional clipped-lane statistics counter built when POLAR_CLIP_STATS_EN is defined.

module axis_polar_clip_framer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LANES      = 1,
  parameter int unsigned FRAME_LEN  = 256,
  parameter int unsigned CLIP_SHIFT = 1
) (
  input  logic                      axis_aclk,
  input  logic                      axis_aresetn,
  input  logic [2*DATA_W:0]         thresh_sq,
  input  logic [2*DATA_W*LANES-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  input  logic [DATA_W*LANES/4-1:0] s_axis_tkeep,
  output logic [2*DATA_W*LANES-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [DATA_W*LANES/4-1:0] m_axis_tkeep,
`ifdef POLAR_CLIP_STATS_EN
  output logic [31:0]               clip_count,
  input  logic                      clip_count_clr,
`endif
  output logic [DATA_W*LANES/4-1:0] m_axis_tstrb
);

  localparam int unsigned SW = 2 * DATA_W;        // one complex sample
  localparam int unsigned TW = SW * LANES;        // TDATA width
  localparam int unsigned KW = DATA_W * LANES / 4; // TKEEP width
  localparam int unsigned MW = SW + 1;            // magnitude-squared width
  localparam int unsigned CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  // Stage state
  logic                       r_s1_valid, r_s2_valid, r_m_valid;
  logic [TW-1:0]              r_s1_data, r_s2_data, r_m_data;
  logic [KW-1:0]              r_s1_keep, r_s2_keep, r_m_keep;
  logic                       r_s1_last, r_s2_last, r_m_last_up;
  logic [MW-1:0]              r_s1_thresh;
  logic [LANES-1:0][SW-1:0]   r_s1_isq, r_s1_qsq;
  logic [CW-1:0]              r_beat_cnt;

  // Handshake / advance wires
  logic w_m_hs, w_s3_ready, w_s2_adv, w_s2_ready, w_s1_adv, w_s1_ready;

  // Datapath wires
  logic signed [SW-1:0]       w_ie [LANES];
  logic signed [SW-1:0]       w_qe [LANES];
  logic [LANES-1:0][SW-1:0]   w_isq, w_qsq;
  logic [LANES-1:0][MW-1:0]   w_mag;
  logic [LANES-1:0]           w_clip;
  logic [TW-1:0]              w_s2_data;

  // A stage may load when empty or when its contents move on in the same cycle.
  assign w_m_hs        = r_m_valid & m_axis_tready;
  assign w_s3_ready    = ~r_m_valid | m_axis_tready;
  assign w_s2_adv      = r_s2_valid & w_s3_ready;
  assign w_s2_ready    = ~r_s2_valid | w_s2_adv;
  assign w_s1_adv      = r_s1_valid & w_s2_ready;
  assign w_s1_ready    = ~r_s1_valid | w_s1_adv;
  assign s_axis_tready = w_s1_ready & axis_aresetn;

  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tdata  = r_m_data;
  assign m_axis_tkeep  = r_m_keep;
  assign m_axis_tstrb  = r_m_keep;
  // Counter only moves on a handshake, so TLAST is stable while stalled.
  assign m_axis_tlast  = r_m_valid & (r_m_last_up | (r_beat_cnt == CW'(FRAME_LEN - 1)));

  // S1 combinational: sign-extend each component and square it.
  always_comb begin
    w_isq = '0;
    w_qsq = '0;
    for (int k = 0; k < LANES; k++) begin
      w_ie[k]  = SW'($signed(s_axis_tdata[SW*k +: DATA_W]));
      w_qe[k]  = SW'($signed(s_axis_tdata[SW*k+DATA_W +: DATA_W]));
      w_isq[k] = w_ie[k] * w_ie[k];
      w_qsq[k] = w_qe[k] * w_qe[k];
    end
  end

  // S2 combinational: sum squares, strict compare, arithmetic shift of clipped lanes.
  always_comb begin
    w_mag     = '0;
    w_clip    = '0;
    w_s2_data = '0;
    for (int k = 0; k < LANES; k++) begin
      w_mag[k]  = {1'b0, r_s1_isq[k]} + {1'b0, r_s1_qsq[k]};
      w_clip[k] = w_mag[k] > r_s1_thresh;
      w_s2_data[SW*k +: DATA_W] = w_clip[k]
          ? DATA_W'($signed(r_s1_data[SW*k +: DATA_W]) >>> CLIP_SHIFT)
          : r_s1_data[SW*k +: DATA_W];
      w_s2_data[SW*k+DATA_W +: DATA_W] = w_clip[k]
          ? DATA_W'($signed(r_s1_data[SW*k+DATA_W +: DATA_W]) >>> CLIP_SHIFT)
          : r_s1_data[SW*k+DATA_W +: DATA_W];
    end
  end

  // S1 register: capture input beat, its threshold and the lane squares.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_keep   <= '0;
      r_s1_last   <= 1'b0;
      r_s1_thresh <= '0;
      r_s1_isq    <= '0;
      r_s1_qsq    <= '0;
    end else if (w_s1_ready) begin
      r_s1_valid <= s_axis_tvalid;
      if (s_axis_tvalid) begin
        r_s1_data   <= s_axis_tdata;
        r_s1_keep   <= s_axis_tkeep;
        r_s1_last   <= s_axis_tlast;
        r_s1_thresh <= thresh_sq;
        r_s1_isq    <= w_isq;
        r_s1_qsq    <= w_qsq;
      end
    end
  end

  // S2 register: clipped samples.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_keep  <= '0;
      r_s2_last  <= 1'b0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_s2_data;
        r_s2_keep <= r_s1_keep;
        r_s2_last <= r_s1_last;
      end
    end
  end

  // S3 output register; contents held until the downstream handshake.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_keep    <= '0;
      r_m_last_up <= 1'b0;
    end else if (w_s3_ready) begin
      r_m_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_m_data    <= r_s2_data;
        r_m_keep    <= r_s2_keep;
        r_m_last_up <= r_s2_last;
      end
    end
  end

  // Frame beat counter; any emitted TLAST (regenerated or upstream) restarts the frame.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_beat_cnt <= '0;
    end else if (w_m_hs) begin
      r_beat_cnt <= m_axis_tlast ? '0 : r_beat_cnt + 1'b1;
    end
  end

`ifdef POLAR_CLIP_STATS_EN
  logic [LANES-1:0] r_s2_clip, r_m_clip;
  logic [31:0]      r_clip_count;
  logic [32:0]      w_cnt_sum;

  assign clip_count = r_clip_count;

  // Per-lane clip flags follow their beat through S2 and S3.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_s2_clip <= '0;
      r_m_clip  <= '0;
    end else begin
      if (w_s2_ready && r_s1_valid) r_s2_clip <= w_clip;
      if (w_s3_ready && r_s2_valid) r_m_clip  <= r_s2_clip;
    end
  end

  // Add the clipped lanes of the departing beat, one bit of headroom for saturation.
  always_comb begin
    w_cnt_sum = {1'b0, r_clip_count};
    for (int k = 0; k < LANES; k++) begin
      w_cnt_sum = w_cnt_sum + 33'(r_m_clip[k]);
    end
  end

  // Saturating clip counter; clear has priority over an increment.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_clip_count <= '0;
    end else if (clip_count_clr) begin
      r_clip_count <= '0;
    end else if (w_m_hs) begin
      r_clip_count <= w_cnt_sum[32] ? 32'hFFFF_FFFF : w_cnt_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_axis_polar_clip_framer.sv
// Self-checking bench for axis_polar_clip_framer (DATA_W=16, LANES=2, FRAME_LEN=4).
// Expected beats are queued at input handshake and compared at output handshake.
// Define POLAR_CLIP_STATS_EN to also exercise the clip counter.

module tb_axis_polar_clip_framer;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned LANES     = 2;
  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned TW        = 2 * DATA_W * LANES;
  localparam int unsigned KW        = DATA_W * LANES / 4;

  logic          clk;
  logic          axis_aresetn;
  logic [32:0]   thresh_sq;
  logic [TW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [KW-1:0] s_axis_tkeep;
  logic [TW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [KW-1:0] m_axis_tkeep;
  logic [KW-1:0] m_axis_tstrb;
`ifdef POLAR_CLIP_STATS_EN
  logic [31:0]   clip_count;
  logic          clip_count_clr;
`endif

  logic rand_mode, rand_rdy, rdy_fix;
  assign m_axis_tready = rand_mode ? rand_rdy : rdy_fix;

  axis_polar_clip_framer #(
    .DATA_W    (DATA_W),
    .LANES     (LANES),
    .FRAME_LEN (FRAME_LEN),
    .CLIP_SHIFT(1)
  ) dut (
    .axis_aclk     (clk),
    .axis_aresetn  (axis_aresetn),
    .thresh_sq     (thresh_sq),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tkeep  (s_axis_tkeep),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tkeep  (m_axis_tkeep),
`ifdef POLAR_CLIP_STATS_EN
    .clip_count    (clip_count),
    .clip_count_clr(clip_count_clr),
`endif
    .m_axis_tstrb  (m_axis_tstrb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rand_rdy = 1'($urandom_range(0, 1));
  end

  typedef struct packed {
    logic [TW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } exp_t;

  exp_t          sb_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            icnt  = 0;
  int            out_idx = 0;
  logic [31:0]   hist;
  logic [TW-1:0] last_out;
  logic          prev_stall = 1'b0;
  logic [TW-1:0] prev_data;
  logic [KW-1:0] prev_keep;
  logic          prev_last;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] pack(input int i0, input int q0, input int i1, input int q1);
    return {q1[15:0], i1[15:0], q0[15:0], i0[15:0]};
  endfunction

  // Reference: mag = I^2+Q^2, clip when strictly above threshold, floor-divide by 2.
  function automatic logic [TW-1:0] model_data(input logic [TW-1:0] d, input logic [32:0] th);
    logic [TW-1:0]      r;
    logic signed [15:0] si, sq;
    longint             li, lq, mag, tl;
    r  = '0;
    tl = longint'(th);
    for (int k = 0; k < LANES; k++) begin
      si  = d[32*k +: 16];
      sq  = d[32*k+16 +: 16];
      li  = si;
      lq  = sq;
      mag = li * li + lq * lq;
      if (mag > tl) begin
        li = li >>> 1;
        lq = lq >>> 1;
      end
      r[32*k +: 16]    = li[15:0];
      r[32*k+16 +: 16] = lq[15:0];
    end
    return r;
  endfunction

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!axis_aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", 64'(m_axis_tvalid), 64'd1);
        check_eq("hold_data", m_axis_tdata, prev_data);
        check_eq("hold_keep", 64'(m_axis_tkeep), 64'(prev_keep));
        check_eq("hold_last", 64'(m_axis_tlast), 64'(prev_last));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb_q.size() == 0) begin
          check_eq("extra_beat_sb_size", 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
          check_eq("out_data", m_axis_tdata, e.data);
          check_eq("out_keep", 64'(m_axis_tkeep), 64'(e.keep));
          check_eq("out_strb", 64'(m_axis_tstrb), 64'(e.keep));
          check_eq("out_last", 64'(m_axis_tlast), 64'(e.last));
          last_out = m_axis_tdata;
          if (out_idx < 32) hist[out_idx] = m_axis_tlast;
          out_idx++;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_keep  = m_axis_tkeep;
      prev_last  = m_axis_tlast;
      if (s_axis_tvalid && s_axis_tready) begin
        e.data = model_data(s_axis_tdata, thresh_sq);
        e.keep = s_axis_tkeep;
        e.last = s_axis_tlast || (icnt == FRAME_LEN - 1);
        icnt   = e.last ? 0 : icnt + 1;
        sb_q.push_back(e);
      end
    end
  end

  // Present a beat and hold it until accepted; returns just after the accepting edge.
  task automatic send_beat(input logic [TW-1:0] d, input logic [32:0] th, input logic lst);
    logic hs;
    int   t;
    s_axis_tdata  = d;
    thresh_sq     = th;
    s_axis_tlast  = lst;
    s_axis_tkeep  = KW'($urandom);
    s_axis_tvalid = 1'b1;
    hs = 1'b0;
    t  = 0;
    while (!hs && t < 500) begin
      @(negedge clk);
      hs = s_axis_tready;
      t++;
    end
    if (!hs) check_eq("send_timeout", 64'(hs), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while ((sb_q.size() != 0 || m_axis_tvalid) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_left", 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hist();
    hist    = '0;
    out_idx = 0;
  endtask

  task automatic do_reset();
    axis_aresetn = 1'b0;
    sb_q.delete();
    icnt = 0;
    clear_hist();
    repeat (2) @(posedge clk);
    #1;
    axis_aresetn = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    axis_aresetn  = 1'b0;
    thresh_sq     = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tkeep  = '0;
    rand_mode     = 1'b0;
    rdy_fix       = 1'b1;
    clear_hist();
`ifdef POLAR_CLIP_STATS_EN
    clip_count_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_eq("rst_m_tdata", m_axis_tdata, 64'd0);
    check_eq("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    check_eq("rst_m_tkeep", 64'(m_axis_tkeep), 64'd0);
    check_eq("rst_m_tstrb", 64'(m_axis_tstrb), 64'd0);
    check_eq("rst_s_tready", 64'(s_axis_tready), 64'd0);
    axis_aresetn = 1'b1;
    @(posedge clk);
    #1;

    // Equal magnitude is not clipped; output appears in cycle 3 after the handshake cycle.
    send_beat(pack(100, 0, -200, 50), 33'd10000, 1'b0);
    idle();
    @(negedge clk);
    check_eq("lat_cyc1", 64'(m_axis_tvalid), 64'd0);
    @(negedge clk);
    check_eq("lat_cyc2", 64'(m_axis_tvalid), 64'd0);
    @(negedge clk);
    check_eq("lat_cyc3", 64'(m_axis_tvalid), 64'd1);
    wait_drain(50);
    check_eq("eq_thresh", last_out, pack(100, 0, -100, 25));

    send_beat(pack(101, 0, -101, 0), 33'd10000, 1'b0);
    idle();
    wait_drain(50);
    check_eq("clip_pos_neg", last_out, pack(50, 0, -51, 0));

    send_beat(pack(-32768, -32768, 0, 0), 33'h7FFF_FFFF, 1'b0);
    idle();
    wait_drain(50);
    check_eq("clip_min", last_out, pack(-16384, -16384, 0, 0));

    send_beat(pack(-32768, -32768, 0, 0), 33'h8000_0000, 1'b0);
    idle();
    wait_drain(50);
    check_eq("pass_min", last_out, pack(-32768, -32768, 0, 0));

    // Regenerated framing, no upstream TLAST.
    do_reset();
    for (int n = 0; n < 10; n++) send_beat(TW'({$urandom, $urandom}), 33'($urandom), 1'b0);
    idle();
    wait_drain(50);
    check_eq("frame_regen", 64'(hist[9:0]), 64'(10'b0010001000));

    // Early upstream TLAST resyncs framing.
    do_reset();
    for (int n = 0; n < 8; n++) send_beat(TW'({$urandom, $urandom}), 33'($urandom), n == 1);
    idle();
    wait_drain(50);
    check_eq("frame_resync", 64'(hist[7:0]), 64'(8'b00100010));

    // Upstream TLAST coinciding with the frame end gives one TLAST only.
    do_reset();
    for (int n = 0; n < 8; n++) send_beat(TW'({$urandom, $urandom}), 33'($urandom), n == 3);
    idle();
    wait_drain(50);
    check_eq("frame_coincide", 64'(hist[7:0]), 64'(8'b10001000));

    // Random backpressure, gaps and TLASTs.
    rand_mode = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk);
        #1;
      end
      send_beat(TW'({$urandom, $urandom}), 33'($urandom_range(0, 32'h7FFF_FFFF)),
                $urandom_range(0, 7) == 0);
    end
    idle();
    wait_drain(5000);
    rand_mode = 1'b0;

    // Reset with three beats stuck in the pipeline.
    rdy_fix = 1'b0;
    for (int n = 0; n < 3; n++) send_beat(TW'({$urandom, $urandom}), 33'($urandom), 1'b0);
    idle();
    @(posedge clk);
    #2;
    axis_aresetn = 1'b0;
    #1;
    check_eq("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_eq("midrst_m_tdata", m_axis_tdata, 64'd0);
    check_eq("midrst_s_tready", 64'(s_axis_tready), 64'd0);
    sb_q.delete();
    icnt = 0;
    clear_hist();
    rdy_fix = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    axis_aresetn = 1'b1;
    for (int n = 0; n < 4; n++) send_beat(TW'({$urandom, $urandom}), 33'($urandom), 1'b0);
    idle();
    wait_drain(50);
    check_eq("postrst_frame", 64'(hist[3:0]), 64'(4'b1000));
    check_eq("postrst_count", 64'(out_idx), 64'd4);

`ifdef POLAR_CLIP_STATS_EN
    do_reset();
    clip_count_clr = 1'b1;
    @(posedge clk);
    #1;
    clip_count_clr = 1'b0;
    check_eq("stats_clr0", 64'(clip_count), 64'd0);
    send_beat(pack(30000, 0, 30000, 0), 33'd100, 1'b0);
    send_beat(pack(30000, 0, 30000, 0), 33'd100, 1'b0);
    send_beat(pack(30000, 0, 1, 0), 33'd100, 1'b0);
    idle();
    wait_drain(50);
    check_eq("stats_five", 64'(clip_count), 64'd5);
    rdy_fix = 1'b0;
    send_beat(pack(30000, 0, 30000, 0), 33'd100, 1'b0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_eq("stats_stalled", 64'(m_axis_tvalid), 64'd1);
    clip_count_clr = 1'b1;
    rdy_fix        = 1'b1;
    @(posedge clk);
    #1;
    clip_count_clr = 1'b0;
    check_eq("stats_clr_wins", 64'(clip_count), 64'd0);
    wait_drain(50);
`endif

    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_polar_clip_framer.md
Name: axis_polar_clip_framer

Overview:
- Parametrised AXI4-Stream PL kernel placed between AIE PLIO streams.
- Replaces the fixed single-lane polar clipper with a multi-lane version.
- Each complex sample whose magnitude squared exceeds a runtime threshold is attenuated by an arithmetic right shift.
- Regenerates TLAST framing every FRAME_LEN beats, so the AIE-bound stream no longer needs TLAST tied high.

Parameters:
- DATA_W, 16: width of each I and Q component (signed two's complement).
- LANES, 1: complex samples per beat. TDATA width = 2*DATA_W*LANES. Lane k uses bits [2*DATA_W*k +: 2*DATA_W], with I in the low half and Q in the high half.
- FRAME_LEN, 256: beats per output frame (≥2).
- CLIP_SHIFT, 1: arithmetic right shift applied to I and Q of a clipped lane.

Ports:
- axis_aclk  in  1  single clock.
- axis_aresetn  in  1  asynchronous, active-low reset.
- thresh_sq  in  2*DATA_W+1  unsigned magnitude-squared limit. Captured with each accepted beat.
- s_axis_tdata  in  2*DATA_W*LANES  input samples.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  upstream frame marker, used for resync.
- s_axis_tkeep  in  DATA_W*LANES/4  byte enables. Passed through.
- m_axis_tdata  out  2*DATA_W*LANES  clipped samples.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  regenerated frame end.
- m_axis_tkeep  out  DATA_W*LANES/4  delayed tkeep.
- m_axis_tstrb  out  DATA_W*LANES/4  equal to m_axis_tkeep.

Behaviour:
- Reset (asynchronous assert, synchronous-released use):
  - all stage valids = 0; m_axis_tvalid = 0; m_axis_tdata = 0; m_axis_tlast = 0; tkeep/tstrb = 0.
  - beat counter = 0; s_axis_tready = 0 while axis_aresetn = 0.
  - Reset mid-stream discards all in-flight beats. No partial frame is flushed.
- Pipeline:
  - Three registered stages: S1 squares, S2 sum+compare+shift, S3 output register.
  - Latency is 3 cycles from input handshake to m_axis_tvalid with no backpressure.
  - Each stage loads when it is empty or its successor loads in the same cycle (bubble-collapsing).
  - s_axis_tready = !S1_valid || S1_advances. It is combinational from the stage state and m_axis_tready.
  - Sustains one beat per cycle with m_axis_tready held high.
- AXI handshake rules:
  - m_axis_tdata, m_axis_tlast and m_axis_tkeep hold stable while m_axis_tvalid=1 and m_axis_tready=0.
  - m_axis_tvalid never drops without a handshake.
- Arithmetic (per lane):
  - mag = I*I + Q*Q, computed at 2*DATA_W+1 bits unsigned. No overflow: (-2^(DATA_W-1))^2 * 2 fits exactly.
  - clip = (mag > thresh_sq), strict greater-than.
  - If clip: I_out = I >>> CLIP_SHIFT and Q_out = Q >>> CLIP_SHIFT (arithmetic shift, rounds toward -inf). Otherwise pass unchanged.
  - thresh_sq travels with its beat, so a threshold change affects only beats accepted after the change.
- Framing:
  - beat counter increments on each output handshake.
  - m_axis_tlast = 1 when counter == FRAME_LEN-1, or when the beat carried s_axis_tlast = 1.
  - Counter wraps to 0 on any output handshake with m_axis_tlast = 1.
  - An early upstream TLAST therefore resyncs framing.
  - Upstream TLAST on exactly beat FRAME_LEN-1 produces a single TLAST, not a double.

Optional Feature:
- Macro: POLAR_CLIP_STATS_EN.
- Defined adds two ports:
  - clip_count  out  32: saturating count of clipped lanes, counted on output handshake. Holds at 0xFFFFFFFF.
  - clip_count_clr  in  1: synchronous clear. Clear wins over a simultaneous increment. Reset value 0.
- Undefined: neither port exists, no counter logic is built, and datapath behaviour is identical.

Test Plan:
- DATA_W=16, LANES=1, thresh_sq=10000, I=100, Q=0 -> out I=100, Q=0 (equal is not clipped); tvalid exactly 3 cycles after handshake.
- thresh_sq=10000, I=101, Q=0 -> out I=50, Q=0; I=-101, Q=0 -> out I=-51.
- I=-32768, Q=-32768, thresh_sq=2^31-1 -> mag=2^31 clipped, out I=Q=-16384; then thresh_sq=2^31 -> same sample passes unchanged.
- FRAME_LEN=4, continuous 10 beats, s_axis_tlast=0 -> m_axis_tlast on output beats 3 and 7.
- FRAME_LEN=4, s_axis_tlast=1 on input beat 1 -> m_axis_tlast on output beats 1 and 5.
- Random m_axis_tready (50%), 1000 beats -> no loss, no duplication, held outputs stable while stalled.
- Reset asserted with 3 beats in flight -> m_axis_tvalid=0 immediately; first post-reset frame TLAST at beat FRAME_LEN-1.
- POLAR_CLIP_STATS_EN: 5 clipped lanes -> clip_count=5; clip_count_clr together with a clipped beat -> 0.
